// File: rtl/arb_mux_nx1_pkg.sv
// Shared definitions for the N:1 arbitrated mux family.
// Holds the mode encodings and the output-stage state type.
package arb_mux_nx1_pkg;

    localparam int MUX_MODE_FIXED = 0;
    localparam int MUX_MODE_RR    = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/arb_mux_nx1_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after PTR,
// wrapping modulo NUM_IN. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] REQ,
    input  logic [SEL_W-1:0]  PTR,
    output logic [NUM_IN-1:0] GRANT,
    output logic [SEL_W-1:0]  GRANT_IDX
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic found;
    int   idx;

    always_comb begin
        GRANT     = '0;
        GRANT_IDX = '0;
        found     = 1'b0;
        idx       = 0;
        // k=1 first so the channel just served gets the lowest priority
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(PTR) + k) % NUM_IN;
            if (!found && REQ[IDX_W'(idx)]) begin
                found                = 1'b1;
                GRANT[IDX_W'(idx)]   = 1'b1;
                GRANT_IDX            = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/arb_mux_nx1.sv
// N-input valid/ready multiplexer with a one-deep registered output stage,
// selecting by SEL (fixed mode) or by round-robin over valid inputs.
module arb_mux_nx1
    import arb_mux_nx1_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = MUX_MODE_FIXED
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    input  logic [NUM_IN-1:0]       IN_VALID,
    output logic [NUM_IN-1:0]       IN_READY,
    input  logic [SEL_W-1:0]        SEL,
    output logic [WIDTH-1:0]        OUT,
    output logic [SEL_W-1:0]        OUT_CHAN,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  sel_data;
    logic              load_en;
    logic              xfer;

    stage_state_e      state_q, state_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [SEL_W-1:0]  chan_q, chan_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            wire unused_sel = ^SEL;
            rr_arbiter #(
                .NUM_IN (NUM_IN),
                .SEL_W  (SEL_W)
            ) u_rr_arbiter (
                .REQ       (IN_VALID),
                .PTR       (ptr_q),
                .GRANT     (grant),
                .GRANT_IDX (grant_idx)
            );
        end else begin : g_fixed
            // SEL values at or above NUM_IN match no channel, so no grant
            for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_dec
                assign grant[gi] = IN_VALID[gi] && (SEL == SEL_W'(gi));
            end
            assign grant_idx = SEL;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | IN_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_en  = (state_q == ST_EMPTY) || OUT_READY;
    assign IN_READY = grant & {NUM_IN{load_en && !RESET}};
    assign xfer     = |(IN_READY & IN_VALID);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = ST_FULL;
            out_d   = sel_data;
            chan_d  = grant_idx;
            if (MODE == MUX_MODE_RR) begin
                ptr_d = grant_idx;
            end
        end else if (OUT_READY) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            chan_q  <= '0;
            ptr_q   <= SEL_W'(NUM_IN - 1);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_CHAN  = chan_q;
    assign OUT_VALID = (state_q == ST_FULL);

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Directed bench for arb_mux_nx1: one fixed-select and one round-robin instance
// sharing stimulus, checked with immediate assertions.
module tb_arb_mux_nx1;
    import arb_mux_nx1_pkg::*;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 4;

    logic                    clk;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic                    out_ready;
    logic [2:0]              sel0;
    logic [1:0]              sel1;

    logic [NUM_IN-1:0] in_ready0, in_ready1;
    logic [WIDTH-1:0]  out0, out1;
    logic [2:0]        out_chan0;
    logic [1:0]        out_chan1;
    logic              out_valid0, out_valid1;

    int total_cnt = 0;
    int pass_cnt  = 0;

    arb_mux_nx1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(3), .MODE(MUX_MODE_FIXED)) dut0 (
        .CLK(clk), .RESET(reset), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready0), .SEL(sel0), .OUT(out0), .OUT_CHAN(out_chan0),
        .OUT_VALID(out_valid0), .OUT_READY(out_ready)
    );

    arb_mux_nx1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(2), .MODE(MUX_MODE_RR)) dut1 (
        .CLK(clk), .RESET(reset), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready1), .SEL(sel1), .OUT(out1), .OUT_CHAN(out_chan1),
        .OUT_VALID(out_valid1), .OUT_READY(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // advance one rising edge, then settle so registered outputs can be sampled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out1(input string tag, input logic [7:0] d, input logic [1:0] c, input logic v);
        chk({tag, "_out"},  32'(out1),       32'(d));
        chk({tag, "_chan"}, 32'(out_chan1),  32'(c));
        chk({tag, "_vld"},  32'(out_valid1), 32'(v));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        sel0      = 3'd0;
        sel1      = 2'd0;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};

        // 1: reset held two cycles with every channel valid
        tick();
        tick();
        chk("rst_rdy0", 32'(in_ready0), 32'h0);
        chk("rst_rdy1", 32'(in_ready1), 32'h0);
        chk("rst_vld0", 32'(out_valid0), 32'h0);
        chk("rst_out0", 32'(out0), 32'h0);
        chk("rst_chan0", 32'(out_chan0), 32'h0);
        chk_out1("rst1", 8'h00, 2'd0, 1'b0);

        // 2: fixed select of channel 2
        reset    = 1'b0;
        sel0     = 3'd2;
        in_valid = 4'b0100;
        in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        #1;
        chk("m0_rdy_sel2", 32'(in_ready0), 32'b0100);
        tick();
        chk("m0_out_a5", 32'(out0), 32'hA5);
        chk("m0_chan2", 32'(out_chan0), 32'd2);
        chk("m0_vld", 32'(out_valid0), 32'd1);
        sel0 = 3'd5;
        #1;
        chk("m0_rdy_sel5", 32'(in_ready0), 32'h0);
        tick();
        chk("m0_drain_vld", 32'(out_valid0), 32'd0);
        chk("m0_drain_out", 32'(out0), 32'hA5);
        chk("m0_drain_chan", 32'(out_chan0), 32'd2);
        sel0     = 3'd0;
        in_valid = 4'b0001;
        tick();
        chk("m0_out_ch0", 32'(out0), 32'h10);
        // stalled while full: a new SEL must not disturb the held word
        out_ready = 1'b0;
        sel0      = 3'd3;
        in_valid  = 4'b1000;
        #1;
        chk("m0_stall_rdy", 32'(in_ready0), 32'h0);
        tick();
        chk("m0_stall_out", 32'(out0), 32'h10);
        chk("m0_stall_chan", 32'(out_chan0), 32'd0);
        chk("m0_stall_vld", 32'(out_valid0), 32'd1);

        // re-reset so the round-robin pointer starts from NUM_IN-1
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;

        // 3: round-robin with all channels valid
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        #1;
        chk("rr_rdy_first", 32'(in_ready1), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out1($sformatf("rr_seq%0d", k), 8'h10 + 8'(k % 4), 2'(k % 4), 1'b1);
        end
        tick();
        chk_out1("rr_seq5", 8'h11, 2'd1, 1'b1);

        // 4: backpressure holds data and priority
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_rdy%0d", k), 32'(in_ready1), 32'h0);
            tick();
            chk_out1($sformatf("bp%0d", k), 8'h11, 2'd1, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(in_ready1), 32'b0100);
        tick();
        chk_out1("bp_rel", 8'h12, 2'd2, 1'b1);

        // 5: sparse requests on channels 0 and 3
        in_valid = 4'b1001;
        tick();
        chk_out1("sp_ch3", 8'h13, 2'd3, 1'b1);
        tick();
        chk_out1("sp_ch0", 8'h10, 2'd0, 1'b1);
        tick();
        chk_out1("sp_ch3b", 8'h13, 2'd3, 1'b1);
        in_valid = 4'b0000;
        tick();
        chk_out1("sp_drain", 8'h13, 2'd3, 1'b0);
        tick();
        chk_out1("sp_idle", 8'h13, 2'd3, 1'b0);

        // 6: reset while full and stalled
        in_valid = 4'b0010;
        tick();
        chk_out1("rf_load", 8'h11, 2'd1, 1'b1);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rf_rdy", 32'(in_ready1), 32'h0);
        tick();
        chk_out1("rf_rst", 8'h00, 2'd0, 1'b0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rf_rdy_rel", 32'(in_ready1), 32'b0001);
        tick();
        chk_out1("rf_first", 8'h10, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
